// File: rtl/regif_cmd_if.sv
// regif_cmd_if: command, register-bus and response-sender signals of the
// register-interface command engine. master = engine side, slave = peers.
interface regif_cmd_if;
  // command from the RX TLP decoder
  logic        cmd_valid;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  // request/acknowledge register bus
  logic        reg_req;
  logic        reg_we;
  logic [31:0] reg_addr;
  logic [63:0] reg_wdata;
  logic        reg_ack;
  logic [63:0] reg_rdata;
  // response handshake towards the TLP sender
  logic        snd_resp;
  logic        snd_resp_ack;
  logic [63:0] resp;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  reg_ack, reg_rdata, snd_resp_ack,
    output reg_req, reg_we, reg_addr, reg_wdata,
    output snd_resp, resp
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output reg_ack, reg_rdata, snd_resp_ack,
    input  reg_req, reg_we, reg_addr, reg_wdata,
    input  snd_resp, resp
  );
endinterface

// File: rtl/regif_cmd.sv
// regif_cmd: executes decoded host register commands on a req/ack register
// bus, returns read (and optionally write) responses to the TLP sender,
// buffers one pending command and times out hung bus accesses.
// Optional feature macro: REGIF_WR_ACK_EN -- writes also produce a response
// word {addr, 31'b0, timed_out} through the SETUP/RESP/DRAIN handshake.
module regif_cmd #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  regif_cmd_if.master bus,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt,
  output logic [7:0]  o_tout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_SETUP,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_tcnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_snd;
  logic [63:0] r_resp;
  logic [7:0]  r_tout;

  logic        r_pend_valid;
  logic        r_pend_wr;
  logic [31:0] r_pend_addr;
  logic [63:0] r_pend_wdata;
  logic [7:0]  r_drop;

  logic        w_busy;
  logic        w_load;
  logic        w_store;
  logic        w_drop;
  logic        w_ld_wr;
  logic [31:0] w_ld_addr;
  logic [63:0] w_ld_wdata;

  // Command selection: pending entry has priority over a fresh strobe in IDLE;
  // a strobe is buffered when busy and empty, or when IDLE frees the buffer.
  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_load  = !w_busy && (r_pend_valid || bus.cmd_valid);
    w_store = bus.cmd_valid && (w_busy ? !r_pend_valid : r_pend_valid);
    w_drop  = bus.cmd_valid && w_busy && r_pend_valid;
    if (r_pend_valid) begin
      w_ld_wr    = r_pend_wr;
      w_ld_addr  = r_pend_addr;
      w_ld_wdata = r_pend_wdata;
    end else begin
      w_ld_wr    = bus.cmd_wr;
      w_ld_addr  = bus.cmd_addr;
      w_ld_wdata = bus.cmd_wdata;
    end
  end

  // One-entry pending buffer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_drop       <= '0;
    end else begin
      if (w_store) begin
        r_pend_valid <= 1'b1;
        r_pend_wr    <= bus.cmd_wr;
        r_pend_addr  <= bus.cmd_addr;
        r_pend_wdata <= bus.cmd_wdata;
      end else if (w_load && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end
      if (w_drop && r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Command FSM: bus access with timeout, then response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_snd   <= 1'b0;
      r_resp  <= '0;
      r_tout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_req   <= 1'b1;
            r_we    <= w_ld_wr;
            r_addr  <= w_ld_addr;
            r_wdata <= w_ld_wdata;
            r_tcnt  <= '0;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          r_tcnt <= r_tcnt + 16'd1;
          // ack is tested first so an ack on the last allowed cycle wins
          if (bus.reg_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_resp  <= bus.reg_rdata;
              r_state <= S_SETUP;
            end else begin
`ifdef REGIF_WR_ACK_EN
              r_resp  <= {r_addr, 31'b0, 1'b0};
              r_state <= S_SETUP;
`else
              r_state <= S_IDLE;
`endif
            end
          end else if (r_tcnt == TMAX) begin
            r_req <= 1'b0;
            if (r_tout != 8'hFF) begin
              r_tout <= r_tout + 8'd1;
            end
            if (!r_we) begin
              r_resp  <= ERR_DATA;
              r_state <= S_SETUP;
            end else begin
`ifdef REGIF_WR_ACK_EN
              r_resp  <= {r_addr, 31'b0, 1'b1};
              r_state <= S_SETUP;
`else
              r_state <= S_IDLE;
`endif
            end
          end
        end
        S_SETUP: begin
          r_snd   <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (bus.snd_resp_ack) begin
            r_snd   <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!bus.snd_resp_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.reg_req   = r_req;
  assign bus.reg_we    = r_we;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.snd_resp  = r_snd;
  assign bus.resp      = r_resp;
  assign o_busy        = w_busy;
  assign o_drop_cnt    = r_drop;
  assign o_tout_cnt    = r_tout;

endmodule

// File: tb/tb_regif_cmd.sv
// tb_regif_cmd: directed + randomized bench for regif_cmd. The reference is
// transaction level: per command it derives the expected request length,
// response word and counter values from the ack cycle and the timeout.
module tb_regif_cmd;
  localparam int unsigned TO  = 256;
  localparam logic [63:0] ERR = 64'hFFFF_FFFF_FFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] drop_cnt;
  logic [7:0] tout_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  int unsigned m_drop = 0;
  int unsigned m_tout = 0;

  regif_cmd_if bus ();

  regif_cmd #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_busy     (busy),
    .o_drop_cnt (drop_cnt),
    .o_tout_cnt (tout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one-cycle command strobe; returns at the negedge of request cycle 1
  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Acts as bus slave and response consumer for one command whose request
  // is in cycle 'start'. Ack is offered in request cycle k (k > TO: never).
  task automatic serve(input logic wr, input logic [31:0] a, input logic [63:0] dw,
                       input int unsigned k, input logic [63:0] rdata,
                       input int unsigned start, input int unsigned hold,
                       input int unsigned alen);
    int unsigned c;
    logic        timed_out;
    logic        want_resp;
    logic [63:0] exp_resp;
    chk("req_up", {63'b0, bus.reg_req}, 64'd1);
    chk("req_addr", {32'b0, bus.reg_addr}, {32'b0, a});
    chk("req_we", {63'b0, bus.reg_we}, {63'b0, wr});
    if (wr) chk("req_wdata", bus.reg_wdata, dw);
    c = start;
    while (c < TO + 8) begin
      if (c == k) begin
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = rdata;
      end
      @(negedge clk);
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = {$urandom, $urandom};
      if (!bus.reg_req) break;
      c++;
    end
    timed_out = (k > TO);
    if (timed_out && m_tout < 255) m_tout++;
    chk("req_cycles", 64'(c), timed_out ? 64'(TO) : 64'(k));
    chk("tout_cnt", {56'b0, tout_cnt}, 64'(m_tout));
    want_resp = !wr;
`ifdef REGIF_WR_ACK_EN
    want_resp = 1'b1;
`endif
    exp_resp = wr ? {a, 31'b0, timed_out} : (timed_out ? ERR : rdata);
    if (!want_resp) begin
      chk("wr_idle", {63'b0, busy}, 64'd0);
      chk("wr_nosnd", {63'b0, bus.snd_resp}, 64'd0);
      return;
    end
    chk("setup_resp", bus.resp, exp_resp);
    chk("setup_snd", {63'b0, bus.snd_resp}, 64'd0);
    @(negedge clk);
    chk("snd_up", {63'b0, bus.snd_resp}, 64'd1);
    chk("resp_val", bus.resp, exp_resp);
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      chk("snd_hold", {63'b0, bus.snd_resp}, 64'd1);
      chk("resp_hold", bus.resp, exp_resp);
    end
    bus.snd_resp_ack = 1'b1;
    for (int i = 0; i < int'(alen); i++) begin
      @(negedge clk);
      chk("snd_down", {63'b0, bus.snd_resp}, 64'd0);
      chk("drain_busy", {63'b0, busy}, 64'd1);
    end
    bus.snd_resp_ack = 1'b0;
    @(negedge clk);
    chk("idle_busy", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, c3;
    logic [63:0] d, e;
    int unsigned k;

    bus.cmd_valid    = 1'b0;
    bus.cmd_wr       = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_wdata    = '0;
    bus.reg_ack      = 1'b0;
    bus.reg_rdata    = '0;
    bus.snd_resp_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", {63'b0, bus.reg_req}, 64'd0);
    chk("rst_snd", {63'b0, bus.snd_resp}, 64'd0);
    chk("rst_resp", bus.resp, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_cnts", {48'b0, drop_cnt, tout_cnt}, 64'd0);

    // directed read: ack in cycle 3, 5-cycle response ack
    issue(1'b0, 32'h10, 64'd0);
    serve(1'b0, 32'h10, 64'd0, 3, 64'h0123_4567_89AB_CDEF, 1, 2, 5);

    // read with no ack: full timeout
    @(negedge clk);
    issue(1'b0, 32'h44, 64'd0);
    serve(1'b0, 32'h44, 64'd0, 1000, 64'd0, 1, 1, 2);

    // ack on the timeout cycle wins
    @(negedge clk);
    issue(1'b0, 32'h48, 64'd0);
    serve(1'b0, 32'h48, 64'd0, TO, 64'hA5A5_0000_1234_5678, 1, 0, 1);

    // write 0x20 with ack in the first request cycle
    @(negedge clk);
    issue(1'b1, 32'h20, 64'hDEAD_BEEF_0000_0001);
    serve(1'b1, 32'h20, 64'hDEAD_BEEF_0000_0001, 1, 64'd0, 1, 1, 1);

    // three back-to-back reads: first runs, second pends, third dropped
    @(negedge clk);
    a = $urandom; b = $urandom; c3 = $urandom;
    d = {$urandom, $urandom}; e = {$urandom, $urandom};
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = a;
    @(negedge clk);
    bus.cmd_addr = b;
    @(negedge clk);
    bus.cmd_addr = c3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    m_drop++;
    chk("drop_cnt", {56'b0, drop_cnt}, 64'(m_drop));
    serve(1'b0, a, 64'd0, 3 + $urandom_range(0, 3), d, 3, 1, 3);
    @(negedge clk);
    serve(1'b0, b, 64'd0, $urandom_range(1, 4), e, 1, 0, 2);
    @(negedge clk);
    chk("third_dropped", {62'b0, bus.reg_req, busy}, 64'd0);

    // randomized commands
    for (int n = 0; n < 8; n++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom; d = {$urandom, $urandom}; e = {$urandom, $urandom};
      k  = $urandom_range(1, 6);
      @(negedge clk);
      issue(wr, a, d);
      serve(wr, a, d, k, e, 1, $urandom_range(0, 3), $urandom_range(1, 6));
    end
    chk("drop_final", {56'b0, drop_cnt}, 64'(m_drop));

    // reset while in RESP with a pending command stored
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 32'h80;
    @(negedge clk);
    bus.cmd_addr  = 32'h84;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.reg_ack   = 1'b0;
    @(negedge clk);
    chk("pre_rst_snd", {63'b0, bus.snd_resp}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_drop = 0; m_tout = 0;
    chk("mid_rst_snd", {63'b0, bus.snd_resp}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_resp", bus.resp, 64'd0);
    chk("mid_rst_cnts", {48'b0, drop_cnt, tout_cnt}, {48'b0, 8'(m_drop), 8'(m_tout)});
    repeat (3) begin
      @(negedge clk);
      chk("pend_lost", {62'b0, bus.reg_req, busy}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
